// File: rtl/vector_lane_sequencer.sv
// Captures two V-element operand vectors plus a scalar on start, then streams them strided over BEATS = V/LANES beats.
// First beat is valid one cycle after start; ready_i low freezes the beat and all lane outputs.
module vector_lane_sequencer #(
    parameter int N     = 32,
    parameter int V     = 20,
    parameter int LANES = 4,
    localparam int BEATS = V / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start_i,
    input  logic [1:0]           OpType,
    input  logic [V*N-1:0]       RD1_VEC_i,
    input  logic [V*N-1:0]       RD2_VEC_i,
    input  logic [N-1:0]         Scalar_i,
    input  logic                 ready_i,
    output logic [LANES*N-1:0]   Vec_A_o,
    output logic [LANES*N-1:0]   Vec_B_o,
    output logic                 valid_o,
    output logic [BW-1:0]        beat_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    if ((V % LANES) != 0) begin : g_bad_geometry
        $error("vector_lane_sequencer: V must be a multiple of LANES");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Element e = l*BEATS + b, so a lane-major view of the packed vector
    // lets each lane index its own slice directly by beat.
    typedef logic [LANES-1:0][BEATS-1:0][N-1:0] vec_t;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            done_q, done_d;
    vec_t            cap1_q, cap1_d;
    vec_t            cap2_q, cap2_d;
    logic [N-1:0]    capsc_q, capsc_d;
    logic [1:0]      mode_q, mode_d;

    logic [LANES-1:0][N-1:0] vec_a;
    logic [LANES-1:0][N-1:0] vec_b;
    logic                    run;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        cap1_d  = cap1_q;
        cap2_d  = cap2_q;
        capsc_d = capsc_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cap1_d  = RD1_VEC_i;
                    cap2_d  = RD2_VEC_i;
                    capsc_d = Scalar_i;
                    mode_d  = OpType;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            done_q  <= 1'b0;
            cap1_q  <= '0;
            cap2_q  <= '0;
            capsc_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
            capsc_q <= capsc_d;
            mode_q  <= mode_d;
        end
    end

    assign run = (state_q == RUN);

    always_comb begin
        vec_a = '0;
        vec_b = '0;
        if (run) begin
            for (int l = 0; l < LANES; l++) begin
                // mode_q[1] swaps operand roles, e.g. scalar-minus-vector
                if (mode_q[1]) begin
                    vec_a[l] = mode_q[0] ? cap2_q[l][beat_q] : capsc_q;
                    vec_b[l] = cap1_q[l][beat_q];
                end else begin
                    vec_a[l] = cap1_q[l][beat_q];
                    vec_b[l] = mode_q[0] ? cap2_q[l][beat_q] : capsc_q;
                end
            end
        end
    end

    assign Vec_A_o = vec_a;
    assign Vec_B_o = vec_b;
    assign valid_o = run;
    assign busy_o  = run;
    assign beat_o  = run ? beat_q : '0;
    assign last_o  = run && (beat_q == LAST_BEAT);
    assign done_o  = done_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
module tb_vector_lane_sequencer;

    localparam int N     = 32;
    localparam int V     = 20;
    localparam int LANES = 4;
    localparam int BW    = 3;

    logic               CLK = 1'b0;
    logic               RST;
    logic               start_i;
    logic [1:0]         OpType;
    logic [V*N-1:0]     RD1_VEC_i;
    logic [V*N-1:0]     RD2_VEC_i;
    logic [N-1:0]       Scalar_i;
    logic               ready_i;
    logic [LANES*N-1:0] Vec_A_o;
    logic [LANES*N-1:0] Vec_B_o;
    logic               valid_o;
    logic [BW-1:0]      beat_o;
    logic               last_o;
    logic               busy_o;
    logic               done_o;

    int checks = 0;
    int errors = 0;

    vector_lane_sequencer #(.N(N), .V(V), .LANES(LANES)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start_i   (start_i),
        .OpType    (OpType),
        .RD1_VEC_i (RD1_VEC_i),
        .RD2_VEC_i (RD2_VEC_i),
        .Scalar_i  (Scalar_i),
        .ready_i   (ready_i),
        .Vec_A_o   (Vec_A_o),
        .Vec_B_o   (Vec_B_o),
        .valid_o   (valid_o),
        .beat_o    (beat_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] lanes4(input int a3, input int a2, input int a1, input int a0);
        return {a3[31:0], a2[31:0], a1[31:0], a0[31:0]};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_busy"},  busy_o,  1'b0);
        chk({tag, "_beat"},  beat_o,  3'd0);
        chk({tag, "_last"},  last_o,  1'b0);
        chk({tag, "_veca"},  Vec_A_o, 128'd0);
        chk({tag, "_vecb"},  Vec_B_o, 128'd0);
    endtask

    // Vector-vector beat b with RD1[i]=i, RD2[i]=100+i: lane l reads element 5*l+b.
    task automatic chk_vv_beat(input string tag, input int b);
        chk({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_beat"},  beat_o,  b[2:0]);
        chk({tag, "_veca"},  Vec_A_o, lanes4(15 + b, 10 + b, 5 + b, b));
        chk({tag, "_vecb"},  Vec_B_o, lanes4(115 + b, 110 + b, 105 + b, 100 + b));
        chk({tag, "_last"},  last_o,  (b == 4));
        chk({tag, "_done"},  done_o,  1'b0);
    endtask

    task automatic load_ramps();
        for (int i = 0; i < V; i++) begin
            RD1_VEC_i[i*N +: N] = N'(i);
            RD2_VEC_i[i*N +: N] = N'(100 + i);
        end
    endtask

    initial begin
        int cyc;
        int exp_b;

        RST = 1'b1; start_i = 1'b1; OpType = 2'b01; ready_i = 1'b1;
        Scalar_i = '0; RD1_VEC_i = '0; RD2_VEC_i = '0;

        // 1: reset held with start asserted
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle("rst");
            chk("rst_done", done_o, 1'b0);
        end
        start_i = 1'b0; RST = 1'b0;
        tick();
        chk_idle("idle");

        // 2: vector-vector, no stall
        load_ramps();
        OpType = 2'b01; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_vv_beat($sformatf("vv_b%0d", b), b);
            tick();
        end
        chk("vv_done", done_o, 1'b1);
        chk_idle("vv_after");
        tick();
        chk("vv_done_pulse", done_o, 1'b0);

        // 3: vector-scalar with swap, inputs changed after capture
        OpType = 2'b10; Scalar_i = 32'hDEADBEEF; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        RD1_VEC_i = '1; Scalar_i = 32'h0; OpType = 2'b01;
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("vs_a_b%0d", b), Vec_A_o,
                lanes4(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
            chk($sformatf("vs_b_b%0d", b), Vec_B_o, lanes4(15 + b, 10 + b, 5 + b, b));
            tick();
        end
        chk("vs_done", done_o, 1'b1);
        tick();

        // 4: backpressure for 3 cycles at beat 2, start during RUN ignored
        load_ramps();
        OpType = 2'b01; start_i = 1'b1;
        tick();
        cyc = 0;
        while (!done_o && cyc < 20) begin
            ready_i = !(cyc >= 2 && cyc <= 4);
            start_i = (cyc >= 2 && cyc <= 4);
            exp_b = (cyc < 2) ? cyc : (cyc <= 5) ? 2 : cyc - 3;
            chk($sformatf("bp_beat_c%0d", cyc), beat_o, exp_b[2:0]);
            chk($sformatf("bp_veca_c%0d", cyc), Vec_A_o,
                lanes4(15 + exp_b, 10 + exp_b, 5 + exp_b, exp_b));
            chk($sformatf("bp_valid_c%0d", cyc), valid_o, 1'b1);
            tick();
            cyc++;
        end
        start_i = 1'b0; ready_i = 1'b1;
        chk("bp_cycles_to_done", cyc, 8);
        chk("bp_done", done_o, 1'b1);
        chk("bp_idle_valid", valid_o, 1'b0);

        // 5: back-to-back start on the done cycle
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("b2b_busy", busy_o, 1'b1);
        chk("b2b_done", done_o, 1'b0);
        chk_vv_beat("b2b_b0", 0);
        tick(); tick(); tick();
        chk_vv_beat("b2b_b3", 3);

        // 6: reset mid-run at beat 3
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_idle("mrst");
        chk("mrst_done", done_o, 1'b0);
        tick();
        chk("mrst_no_done", done_o, 1'b0);
        chk("mrst_still_idle", valid_o, 1'b0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk_vv_beat($sformatf("replay_b%0d", b), b);
            tick();
        end
        chk("replay_done", done_o, 1'b1);
        tick();
        chk("replay_done_pulse", done_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
Parametrised successor of the vector fork stage. Captures two V-element operand vectors plus a scalar on a start pulse, then streams them to a LANES-wide ALU array over BEATS = V/LANES beats, using a strided element mapping and a valid/ready handshake. Sits between the vector register file read ports and the lane ALUs. Unlike the previous fork stage, it adds operand buffering, backpressure, a swap mode, and a done pulse.

Parameters:
N, 32, element width in bits
V, 20, elements per vector; must be a multiple of LANES (elaboration-time assertion)
LANES, 4, parallel output lanes
BEATS, V/LANES (derived localparam), beats per vector
BW, $clog2(BEATS) min 1 (derived localparam), beat counter width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-high
start_i  in  1  request a new vector operation; sampled only in IDLE
OpType  in  2  bit0: 1 = vector-vector, 0 = vector-scalar; bit1: 1 = swap A/B; captured at start
RD1_VEC_i  in  V*N  operand vector 1, packed [V-1:0][N-1:0]
RD2_VEC_i  in  V*N  operand vector 2, packed [V-1:0][N-1:0]
Scalar_i  in  N  scalar operand
ready_i  in  1  downstream accepts the current beat
Vec_A_o  out  LANES*N  lane A operands, packed [LANES-1:0][N-1:0]
Vec_B_o  out  LANES*N  lane B operands, packed [LANES-1:0][N-1:0]
valid_o  out  1  Vec_A_o/Vec_B_o hold a valid beat
beat_o  out  BW  index of the current beat
last_o  out  1  current beat is BEATS-1 (qualified by valid_o)
busy_o  out  1  state is RUN
done_o  out  1  one-cycle pulse after the final beat handshake

Behaviour:
- FSM states: IDLE, RUN. On reset: state=IDLE, beat=0, done_o=0, captured buffers and mode=0. All outputs read 0 during and after reset.
- IDLE & start_i: capture RD1_VEC_i, RD2_VEC_i, Scalar_i and OpType into internal registers; set beat=0; go to RUN.
- First valid_o appears in the cycle after start_i (1-cycle latency).
- Operand sources are the captured copies, so input changes after start have no effect on the running operation.
- RUN: valid_o=1. Beat advances only when valid_o & ready_i.
- ready_i=0: outputs and beat are held stable. Any number of stall cycles is allowed.
- Handshake on beat BEATS-1: return to IDLE and set done_o=1 for exactly the next cycle.
- start_i while RUN is ignored and not queued.
- start_i in the cycle done_o is high is accepted, because state is already IDLE. Back-to-back operations therefore have one bubble cycle.
- Lane mapping for lane l at beat b: element index e = l*BEATS + b. Example with V=20, LANES=4: lane 2 at beat 3 reads element 13.
- Pre-swap operands:
  - A = cap1[e]
  - B = OpType[0] ? cap2[e] : capScalar
- OpType[1]=1 exchanges A and B on every lane, e.g. scalar-minus-vector.
- Vec_A_o, Vec_B_o and last_o are combinational from captured state and beat, and are forced to 0 when valid_o=0.
- beat_o reads 0 in IDLE.
- BEATS=1 (LANES=V): a single beat with last_o=1 on it. Counter logic must not overflow or wrap incorrectly.
- RST asserted mid-RUN: abort next edge to IDLE, no done_o, beat=0, buffers cleared.
- RST has priority over start_i in the same cycle.
- No arithmetic is performed; values pass through unchanged at full N bits.

Test Plan:
1. Reset then idle: hold RST 3 cycles with start_i=1 -> valid_o, busy_o, done_o, beat_o, Vec_A_o all 0.
2. Vector-vector, no stall (N=32, V=20, LANES=4): RD1[i]=i, RD2[i]=100+i, OpType=01, ready_i=1, start pulse -> 5 valid beats with beat b giving Vec_A_o={15+b,10+b,5+b,b} and Vec_B_o=+100 of each; last_o on beat 4; done_o one cycle later.
3. Vector-scalar with swap: OpType=10, Scalar_i=32'hDEADBEEF -> Vec_A_o all lanes 0xDEADBEEF, Vec_B_o lanes = RD1 strided elements; change RD1_VEC_i after start -> outputs unchanged.
4. Backpressure: ready_i low for 3 cycles at beat 2 -> beat_o stays 2 and outputs stay stable; 8 cycles from first valid to done_o; start_i during RUN ignored.
5. Back-to-back: start_i asserted on the done_o cycle -> second operation starts with valid_o in the following cycle and beat_o=0.
6. Mid-run reset at beat 3 -> next cycle IDLE, all outputs 0, no done_o; fresh start replays from beat 0.
